mem_stage: RTL and testbench

- Memory-access stage of the five-stage pipeline; sits directly downstream of the execute stage and upstream of write-back.
- Consumes the EX/Mem pipeline register contents: ALU result (address or result), store data, memory-op code, destination register, PC and hazard timing.
- Performs word, half and byte loads and stores to an internal data memory, then registers the result into the Mem/WB pipeline register.
- Exports its in-stage hazard fields to the hazard unit.

---
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage: data memory, load extend, Mem/WB register.
// Optional store trace enabled by defining DM_WRITE_DISPLAY_EN.
module mem_stage #(
    parameter int          DM_WORDS = 3072,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_EX_to_Mem,
    input  logic [4:0]  RegWriteAddr_EX_to_Mem,
    input  logic [31:0] ALUOut_EX_to_Mem,
    input  logic [31:0] DMWriteData_EX_to_Mem,
    input  logic [3:0]  MemOp_EX_to_Mem,
    input  logic [2:0]  Tnew_WAddr_EX_to_Mem,
    input  logic [31:0] bypass_WB,
    input  logic        DMWriteDataBypassCtrl,
    output logic [31:0] PC_Mem_to_WB,
    output logic [4:0]  RegWriteAddr_Mem_to_WB,
    output logic [31:0] WBData_Mem_to_WB,
    output logic [2:0]  Tnew_WAddr_Mem_to_WB,
    output logic [4:0]  RegWriteAddr_Mem,
    output logic [2:0]  Tnew_WAddr_Mem,
    output logic [31:0] bypass_Mem
);
    localparam int AW = $clog2(DM_WORDS);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic [31:0] mem_q [DM_WORDS];

    logic [31:0] pc_q, wbdata_q, wbdata_d;
    logic [4:0]  rwa_q;
    logic [2:0]  tnew_q, tnew_d;

    logic [29:0]   widx;
    logic [1:0]    boff;
    logic          in_range;
    logic [AW-1:0] waddr;
    logic [31:0]   sd, rd_word, st_word, ld_data;
    logic [15:0]   half;
    logic [7:0]    byte_sel;
    logic          is_store, is_load;

    assign widx     = ALUOut_EX_to_Mem[31:2];
    assign boff     = ALUOut_EX_to_Mem[1:0];
    assign in_range = ({2'b00, widx} < 32'(DM_WORDS));
    assign waddr    = widx[AW-1:0];
    assign sd       = DMWriteDataBypassCtrl ? bypass_WB : DMWriteData_EX_to_Mem;
    assign rd_word  = in_range ? mem_q[waddr] : 32'd0;
    assign half     = boff[1] ? rd_word[31:16] : rd_word[15:0];
    assign byte_sel = rd_word[8*boff +: 8];
    assign is_store = (MemOp_EX_to_Mem == OP_SW) || (MemOp_EX_to_Mem == OP_SH) ||
                      (MemOp_EX_to_Mem == OP_SB);
    assign is_load  = (MemOp_EX_to_Mem >= OP_LW) && (MemOp_EX_to_Mem <= OP_LBU);
    assign tnew_d   = (Tnew_WAddr_EX_to_Mem != 3'd0) ? Tnew_WAddr_EX_to_Mem - 3'd1 : 3'd0;

    // Read-modify-write merge: untouched lanes keep the current word.
    always_comb begin
        st_word = rd_word;
        case (MemOp_EX_to_Mem)
            OP_SW:   st_word = sd;
            OP_SH:   if (boff[1]) st_word[31:16] = sd[15:0];
                     else         st_word[15:0]  = sd[15:0];
            OP_SB:   st_word[8*boff +: 8] = sd[7:0];
            default: st_word = rd_word;
        endcase
    end

    always_comb begin
        ld_data = 32'd0;
        case (MemOp_EX_to_Mem)
            OP_LW:   ld_data = rd_word;
            OP_LH:   ld_data = {{16{half[15]}}, half};
            OP_LHU:  ld_data = {16'd0, half};
            OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_data = {24'd0, byte_sel};
            default: ld_data = 32'd0;
        endcase
        wbdata_d = is_load ? ld_data : ALUOut_EX_to_Mem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= 32'd0;
        end else if (is_store && in_range) begin
            mem_q[waddr] <= st_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            rwa_q    <= 5'd0;
            wbdata_q <= 32'd0;
            tnew_q   <= 3'd0;
        end else begin
            pc_q     <= PC_EX_to_Mem;
            rwa_q    <= RegWriteAddr_EX_to_Mem;
            wbdata_q <= wbdata_d;
            tnew_q   <= tnew_d;
        end
    end

`ifdef DM_WRITE_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset && is_store && in_range)
            $display("@%h: *%h <= %h", PC_EX_to_Mem, {widx, 2'b00}, st_word);
    end
`else
`endif

    assign PC_Mem_to_WB           = pc_q;
    assign RegWriteAddr_Mem_to_WB = rwa_q;
    assign WBData_Mem_to_WB       = wbdata_q;
    assign Tnew_WAddr_Mem_to_WB   = tnew_q;
    assign RegWriteAddr_Mem       = RegWriteAddr_EX_to_Mem;
    assign Tnew_WAddr_Mem         = tnew_d;
    assign bypass_Mem             = ALUOut_EX_to_Mem;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, alu_in, wd_in, byp_in;
    logic [4:0]  rwa_in;
    logic [3:0]  op_in;
    logic [2:0]  tnew_in;
    logic        bctrl_in;
    logic [31:0] pc_wb, wbdata_wb, byp_mem;
    logic [4:0]  rwa_wb, rwa_mem;
    logic [2:0]  tnew_wb, tnew_mem;

    int passed = 0;
    int total  = 0;

    mem_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .PC_EX_to_Mem           (pc_in),
        .RegWriteAddr_EX_to_Mem (rwa_in),
        .ALUOut_EX_to_Mem       (alu_in),
        .DMWriteData_EX_to_Mem  (wd_in),
        .MemOp_EX_to_Mem        (op_in),
        .Tnew_WAddr_EX_to_Mem   (tnew_in),
        .bypass_WB              (byp_in),
        .DMWriteDataBypassCtrl  (bctrl_in),
        .PC_Mem_to_WB           (pc_wb),
        .RegWriteAddr_Mem_to_WB (rwa_wb),
        .WBData_Mem_to_WB       (wbdata_wb),
        .Tnew_WAddr_Mem_to_WB   (tnew_wb),
        .RegWriteAddr_Mem       (rwa_mem),
        .Tnew_WAddr_Mem         (tnew_mem),
        .bypass_Mem             (byp_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        bctrl;
        logic [31:0] byp;
        logic [4:0]  rwa;
        logic [2:0]  tnew;
        logic [31:0] exp_wb;
        logic [2:0]  exp_tnew;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wd,
                                input logic bctrl, input logic [31:0] byp, input logic [4:0] rwa,
                                input logic [2:0] tnew, input logic [31:0] exp_wb,
                                input logic [2:0] exp_tnew);
        vec_t v;
        v.op = op; v.alu = alu; v.wd = wd; v.bctrl = bctrl; v.byp = byp;
        v.rwa = rwa; v.tnew = tnew; v.exp_wb = exp_wb; v.exp_tnew = exp_tnew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc);
        op_in = op; alu_in = alu; wd_in = wd; pc_in = pc;
        bctrl_in = 1'b0; byp_in = 32'd0; rwa_in = 5'd0; tnew_in = 3'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] pc;
        pc = 32'h0000_3000 + 32'(idx * 4);
        @(negedge clk);
        op_in = v.op; alu_in = v.alu; wd_in = v.wd; bctrl_in = v.bctrl; byp_in = v.byp;
        rwa_in = v.rwa; tnew_in = v.tnew; pc_in = pc;
        #1;
        check($sformatf("v%0d tnew_mem", idx), 32'(tnew_mem), 32'(v.exp_tnew));
        check($sformatf("v%0d rwa_mem", idx), 32'(rwa_mem), 32'(v.rwa));
        check($sformatf("v%0d bypass_mem", idx), byp_mem, v.alu);
        @(posedge clk);
        #1;
        check($sformatf("v%0d wbdata", idx), wbdata_wb, v.exp_wb);
        check($sformatf("v%0d tnew_wb", idx), 32'(tnew_wb), 32'(v.exp_tnew));
        check($sformatf("v%0d pc_wb", idx), pc_wb, pc);
        check($sformatf("v%0d rwa_wb", idx), 32'(rwa_wb), 32'(v.rwa));
    endtask

    initial begin
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 32'd0);
        #2;
        check("reset pc", pc_wb, 32'h0000_3000);
        check("reset wbdata", wbdata_wb, 32'd0);
        check("reset rwa", 32'(rwa_wb), 32'd0);
        check("reset tnew", 32'(tnew_wb), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //          op    alu            wd             bc   bypass         rwa    tn    exp_wb         exp_tn
        vecs.push_back(mk(4'd6, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        5'd0,  3'd0, 32'h10,        3'd0));
        vecs.push_back(mk(4'd1, 32'h10,   32'h0,        1'b0, 32'h0,        5'd5,  3'd2, 32'hDEADBEEF,  3'd1));
        vecs.push_back(mk(4'd8, 32'h13,   32'hAA,       1'b0, 32'h0,        5'd0,  3'd0, 32'h13,        3'd0));
        vecs.push_back(mk(4'd1, 32'h10,   32'h0,        1'b0, 32'h0,        5'd6,  3'd4, 32'hAAADBEEF,  3'd3));
        vecs.push_back(mk(4'd4, 32'h13,   32'h0,        1'b0, 32'h0,        5'd7,  3'd1, 32'hFFFFFFAA,  3'd0));
        vecs.push_back(mk(4'd5, 32'h13,   32'h0,        1'b0, 32'h0,        5'd8,  3'd7, 32'h000000AA,  3'd6));
        vecs.push_back(mk(4'd6, 32'h20,   32'h0,        1'b0, 32'h0,        5'd0,  3'd0, 32'h20,        3'd0));
        vecs.push_back(mk(4'd7, 32'h22,   32'h8001,     1'b0, 32'h0,        5'd3,  3'd0, 32'h22,        3'd0));
        vecs.push_back(mk(4'd1, 32'h20,   32'h0,        1'b0, 32'h0,        5'd9,  3'd2, 32'h80010000,  3'd1));
        vecs.push_back(mk(4'd2, 32'h22,   32'h0,        1'b0, 32'h0,        5'd9,  3'd2, 32'hFFFF8001,  3'd1));
        vecs.push_back(mk(4'd3, 32'h22,   32'h0,        1'b0, 32'h0,        5'd9,  3'd2, 32'h00008001,  3'd1));
        vecs.push_back(mk(4'd6, 32'h30,   32'h0,        1'b1, 32'h12345678, 5'd0,  3'd0, 32'h30,        3'd0));
        vecs.push_back(mk(4'd1, 32'h30,   32'h0,        1'b0, 32'h0,        5'd1,  3'd2, 32'h12345678,  3'd1));
        vecs.push_back(mk(4'd6, 32'h3000, 32'hCAFEF00D, 1'b0, 32'h0,        5'd0,  3'd0, 32'h3000,      3'd0));
        vecs.push_back(mk(4'd1, 32'h3000, 32'h0,        1'b0, 32'h0,        5'd2,  3'd2, 32'h0,         3'd1));
        vecs.push_back(mk(4'd1, 32'h80000010, 32'h0,    1'b0, 32'h0,        5'd2,  3'd2, 32'h0,         3'd1));
        vecs.push_back(mk(4'd6, 32'h2FFC, 32'h5A5A5A5A, 1'b0, 32'h0,        5'd0,  3'd0, 32'h2FFC,      3'd0));
        vecs.push_back(mk(4'd1, 32'h2FFC, 32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'h5A5A5A5A,  3'd1));
        vecs.push_back(mk(4'd1, 32'h11,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'hAAADBEEF,  3'd1));
        vecs.push_back(mk(4'd4, 32'h12,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'hFFFFFFAD,  3'd1));
        vecs.push_back(mk(4'd2, 32'h10,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'hFFFFBEEF,  3'd1));
        vecs.push_back(mk(4'd3, 32'h11,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'h0000BEEF,  3'd1));
        vecs.push_back(mk(4'd8, 32'h20,   32'h1234567F, 1'b0, 32'h0,        5'd0,  3'd0, 32'h20,        3'd0));
        vecs.push_back(mk(4'd4, 32'h20,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'h0000007F,  3'd1));
        vecs.push_back(mk(4'd1, 32'h20,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'h8001007F,  3'd1));
        vecs.push_back(mk(4'd7, 32'h30,   32'hFFFF5555, 1'b0, 32'h0,        5'd0,  3'd0, 32'h30,        3'd0));
        vecs.push_back(mk(4'd1, 32'h30,   32'h0,        1'b0, 32'h0,        5'd4,  3'd2, 32'h12345555,  3'd1));
        vecs.push_back(mk(4'd9, 32'h1234, 32'h0,        1'b0, 32'h0,        5'd11, 3'd3, 32'h1234,      3'd2));
        vecs.push_back(mk(4'd0, 32'h5555, 32'h0,        1'b0, 32'h0,        5'd12, 3'd5, 32'h5555,      3'd4));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Asynchronous reset pulsed between edges must clear outputs and memory at once.
        @(negedge clk);
        drive(4'd0, 32'h0, 32'h0, 32'h4444);
        #2;
        reset = 1'b1;
        #1;
        check("async pc", pc_wb, 32'h0000_3000);
        check("async wbdata", wbdata_wb, 32'd0);
        check("async rwa", 32'(rwa_wb), 32'd0);
        check("async tnew", 32'(tnew_wb), 32'd0);
        // Store held across an edge while reset is high is dropped.
        drive(4'd6, 32'h40, 32'h11111111, 32'h4448);
        @(posedge clk);
        #1;
        check("reset hold pc", pc_wb, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b0;

        drive(4'd1, 32'h10, 32'h0, 32'h5000);
        @(posedge clk); #1;
        check("post-reset lw 0x10", wbdata_wb, 32'd0);
        @(negedge clk);
        drive(4'd1, 32'h2FFC, 32'h0, 32'h5004);
        @(posedge clk); #1;
        check("post-reset lw 0x2ffc", wbdata_wb, 32'd0);
        @(negedge clk);
        drive(4'd1, 32'h40, 32'h0, 32'h5008);
        @(posedge clk); #1;
        check("dropped store 0x40", wbdata_wb, 32'd0);
        check("post-reset pc", pc_wb, 32'h5008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
